lcd_hd44780_ctrl: RTL and testbench
===================================

// Module: lcd_hd44780_ctrl
// PURPOSE
// - Responder side of the CPU LCD port. Accepts one byte-wide command/data write per valid/ready handshake.
// - Generates HD44780 bus timing at CLOCK_50: setup, EN pulse, hold and execute wait.
// - Replaces software bit-banging of LCD_EN; sits between the LSU LCD register and the LCD_* pins.
// PARAMETERS
// - T_SETUP_CYC  4       cycles RS/DATA stable before EN rises
// - T_EN_CYC     12      cycles EN held high (>=230 ns at 50 MHz)
// - T_HOLD_CYC   2       cycles RS/DATA held after EN falls
// - T_EXEC_CYC   2500    execute wait for normal cmd/data (50 us)
// - T_CLEAR_CYC  82000   execute wait for clear/home cmds (1.64 ms)
// - T_PWR_CYC    750000  power-on wait before init sequence (15 ms; INIT only)
// PORTS
// - clk        in   1  system clock, CLOCK_50
// - rst        in   1  synchronous reset, active-high
// - req_valid  in   1  write request valid
// - req_ready  out  1  controller idle; request accepted on valid&&ready at rising clk
// - req_rs     in   1  0 = command, 1 = data
// - req_data   in   8  byte to write
// - busy       out  1  equals ~req_ready
// - lcd_data   out  8  LCD_DATA
// - lcd_rw     out  1  LCD_RW; tied 0 (write-only)
// - lcd_rs     out  1  LCD_RS
// - lcd_en     out  1  LCD_EN
// - lcd_on     out  1  LCD_ON
// BEHAVIOUR
// - Clocking and reset: one clock, clk. Reset rst is synchronous, active-high.
// - Reset values: lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_on=0, req_ready=0, busy=1.
// - First edge after rst deasserts: lcd_on=1 and stays 1. Then FSM enters IDLE, or INIT_PWR when init is compiled in.
// - States: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE. One down-counter, width $clog2(max param+1).
// - Each state lasts max(1,T_x) cycles.
// - IDLE: req_ready=1. Accept at edge k latches req_rs/req_data into lcd_rs/lcd_data after edge k; state becomes SETUP.
// - lcd_data/lcd_rs remain stable until the next accept.
// - Timing after an accept at edge k:
//   - lcd_en=1 from edge k+S to edge k+S+E; 0 at all other times.
//   - req_ready returns to 1 after edge k+S+E+H+W.
// - W = T_CLEAR_CYC when latched rs=0 and data is in {0x01,0x02,0x03}; otherwise W = T_EXEC_CYC.
// - req_valid while req_ready=0 is ignored. Input changes while busy are ignored; nothing is queued.
// - Back-to-back: valid held high is accepted on the first ready cycle, so the minimum accept spacing is S+E+H+W+1 edges.
// - rst mid-transfer: lcd_en drops to 0 at that edge and the in-flight request is abandoned, never replayed.
// - lcd_rw is constant 0. Busy-flag reads are not supported.
// CONFIGURATION
// - LCD_INIT_EN defined:
//   - After reset, INIT_PWR waits T_PWR_CYC.
//   - Then issues cmds 0x38, 0x0C, 0x01, 0x06 (rs=0) through the same SETUP..WAIT engine.
//   - 0x01 uses T_CLEAR_CYC. req_ready stays 0 until the sequence completes, then IDLE.
// - LCD_INIT_EN undefined: no init logic; IDLE on the first cycle after reset; software performs init.
// TESTING (sim params S=2 E=3 H=1 W=T_EXEC_CYC=5 C=T_CLEAR_CYC=20 P=T_PWR_CYC=10)
// - rst=1 for 3 cycles -> all outputs 0, req_ready=0; release -> lcd_on=1 and req_ready=1 at first edge (no INIT).
// - Accept rs=1 data=0x41 at edge k:
//   - lcd_data=0x41 and lcd_rs=1 after k.
//   - lcd_en=1 for edges k+2..k+5.
//   - req_ready=1 after k+11.
// - Accept rs=0 data=0x01 -> same EN window; req_ready returns after k+26 (clear wait).
// - req_valid held high with 0x48 then 0x49:
//   - second byte accepted exactly at first ready edge.
//   - two distinct EN pulses, each 3 cycles.
//   - data change during busy has no effect.
// - Assert rst during PULSE -> lcd_en=0 after that edge; after release req_ready=1 and no further EN pulse.
// - LCD_INIT_EN:
//   - after reset, 10-cycle wait, then 4 EN pulses with lcd_data 0x38, 0x0C, 0x01, 0x06 and rs=0.
//   - req_valid pulses during init ignored; req_ready rises only after the 0x06 wait.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl
// Responder side of the CPU LCD port. One command/data byte is accepted per
// req_valid/req_ready handshake. Each byte is replayed onto the HD44780 bus
// with setup, EN pulse, hold and execute-wait timing, so software never has
// to bit-bang LCD_EN.
//
// Optional feature macro: LCD_INIT_EN
//   defined   : after reset wait T_PWR_CYC, then send 0x38, 0x0C, 0x01, 0x06
//               before the controller reports ready.
//   undefined : controller is idle on the first cycle after reset, and
//               software is responsible for initialising the display.
//
// Ports
//   clk        in   system clock (CLOCK_50)
//   rst        in   synchronous reset, active-high
//   req_valid  in   write request valid
//   req_ready  out  controller idle; accept on req_valid && req_ready
//   req_rs     in   0 = command, 1 = data
//   req_data   in   byte to write
//   busy       out  ~req_ready
//   lcd_data   out  LCD_DATA
//   lcd_rw     out  LCD_RW, constant 0 (write-only)
//   lcd_rs     out  LCD_RS
//   lcd_en     out  LCD_EN
//   lcd_on     out  LCD_ON
//
// state    | meaning
// ---------+----------------------------------------------------------
// BOOT     | first cycle after reset; turns the panel on
// INIT_PWR | power-on wait before the init sequence (LCD_INIT_EN only)
// IDLE     | req_ready high, waiting for a request
// SETUP    | RS/DATA driven, EN low
// PULSE    | EN high
// HOLD     | EN low again, RS/DATA still held
// WAIT     | execute wait for the LCD (normal or clear/home time)

module lcd_hd44780_ctrl #(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2500,
  parameter int T_CLEAR_CYC = 82000,
  parameter int T_PWR_CYC   = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       lcd_on
);

  // Every state lasts at least one cycle, even if its parameter is 0.
  localparam int S_L = (T_SETUP_CYC < 1) ? 1 : T_SETUP_CYC;
  localparam int E_L = (T_EN_CYC    < 1) ? 1 : T_EN_CYC;
  localparam int H_L = (T_HOLD_CYC  < 1) ? 1 : T_HOLD_CYC;
  localparam int X_L = (T_EXEC_CYC  < 1) ? 1 : T_EXEC_CYC;
  localparam int C_L = (T_CLEAR_CYC < 1) ? 1 : T_CLEAR_CYC;
  localparam int P_L = (T_PWR_CYC   < 1) ? 1 : T_PWR_CYC;

  localparam int M1   = (S_L > E_L) ? S_L : E_L;
  localparam int M2   = (M1  > H_L) ? M1  : H_L;
  localparam int M3   = (M2  > X_L) ? M2  : X_L;
  localparam int M4   = (M3  > C_L) ? M3  : C_L;
  localparam int MAXC = (M4  > P_L) ? M4  : P_L;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_INIT_PWR,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_clear(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

`ifdef LCD_INIT_EN
  logic [2:0] init_idx;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction
`endif

  assign lcd_rw = 1'b0;
  assign busy   = ~req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BOOT;
      cnt       <= '0;
      lcd_data  <= '0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_on    <= 1'b0;
      req_ready <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx  <= '0;
`endif
    end else begin
      case (state)
        ST_BOOT: begin
          lcd_on <= 1'b1;
`ifdef LCD_INIT_EN
          state    <= ST_INIT_PWR;
          cnt      <= CW'(P_L - 1);
          init_idx <= '0;
`else
          state     <= ST_IDLE;
          req_ready <= 1'b1;
`endif
        end

        ST_INIT_PWR: begin
`ifdef LCD_INIT_EN
          if (cnt == '0) begin
            lcd_rs   <= 1'b0;
            lcd_data <= init_cmd(init_idx[1:0]);
            init_idx <= init_idx + 3'd1;
            state    <= ST_SETUP;
            cnt      <= CW'(S_L - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
`else
          state     <= ST_IDLE;
          req_ready <= 1'b1;
`endif
        end

        ST_IDLE: begin
          if (req_valid) begin
            lcd_rs    <= req_rs;
            lcd_data  <= req_data;
            req_ready <= 1'b0;
            state     <= ST_SETUP;
            cnt       <= CW'(S_L - 1);
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            state  <= ST_PULSE;
            cnt    <= CW'(E_L - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            state  <= ST_HOLD;
            cnt    <= CW'(H_L - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_WAIT;
            cnt   <= is_clear(lcd_rs, lcd_data) ? CW'(C_L - 1) : CW'(X_L - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WAIT: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_EN
            if (init_idx != 3'd4) begin
              // Next init command goes straight into SETUP, as if accepted.
              lcd_rs   <= 1'b0;
              lcd_data <= init_cmd(init_idx[1:0]);
              init_idx <= init_idx + 3'd1;
              state    <= ST_SETUP;
              cnt      <= CW'(S_L - 1);
            end else begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
            end
`else
            state     <= ST_IDLE;
            req_ready <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Testbench for lcd_hd44780_ctrl. The reference model works in edge numbers:
// every accepted byte schedules an EN window and a ready-return edge from the
// timing rules, and each cycle the outputs are compared with that schedule.
module tb_lcd_hd44780_ctrl;

  localparam int S = 2;
  localparam int E = 3;
  localparam int H = 1;
  localparam int W = 5;
  localparam int C = 20;
  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_rw;
  logic       lcd_rs;
  logic       lcd_en;
  logic       lcd_on;

  lcd_hd44780_ctrl #(
    .T_SETUP_CYC(S),
    .T_EN_CYC   (E),
    .T_HOLD_CYC (H),
    .T_EXEC_CYC (W),
    .T_CLEAR_CYC(C),
    .T_PWR_CYC  (P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs   (req_rs),
    .req_data (req_data),
    .busy     (busy),
    .lcd_data (lcd_data),
    .lcd_rw   (lcd_rw),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_on   (lcd_on)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  // model state
  bit         m_rdy;
  bit         m_on;
  bit         m_rs;
  logic [7:0] m_data;
  int         en_on, en_off, done_at;
  int         init_idx;
  bit         booted;
  bit         m_acc;
  int         m_pulses = 0;
  int         obs_pulses = 0;
  bit         prev_en = 1'b0;
  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  task automatic issue(input bit rs, input logic [7:0] d);
    bit clr;
    clr     = !rs && d >= 8'h01 && d <= 8'h03;
    m_rs    = rs;
    m_data  = d;
    en_on   = edge_n + S;
    en_off  = edge_n + S + E;
    done_at = edge_n + S + E + H + (clr ? C : W);
  endtask

  // One clock edge: update the model from the inputs seen at that edge,
  // then compare every output 1 time unit later.
  task automatic step();
    bit exp_en;
    @(posedge clk);
    edge_n++;
    m_acc = 1'b0;
    if (rst) begin
      m_rdy = 0; m_on = 0; m_rs = 0; m_data = 8'h00;
      en_on = 0; en_off = 0; done_at = -1; booted = 0;
    end else if (!booted) begin
      booted = 1;
      m_on   = 1;
`ifdef LCD_INIT_EN
      init_idx = 0;
      done_at  = edge_n + P;
      m_rdy    = 0;
`else
      init_idx = 4;
      m_rdy    = 1;
`endif
    end else if (m_rdy) begin
      if (req_valid) begin
        issue(req_rs, req_data);
        m_rdy = 0;
        m_acc = 1;
      end
    end else if (edge_n == done_at) begin
      if (init_idx < 4) begin
        issue(1'b0, init_cmds[init_idx]);
        init_idx++;
      end else begin
        m_rdy = 1;
      end
    end
    if (!rst && booted && edge_n == en_on) m_pulses++;
    exp_en = (edge_n >= en_on) && (edge_n < en_off);
    #1;
    check("req_ready", req_ready, m_rdy);
    check("busy", busy, !m_rdy);
    check("lcd_en", lcd_en, exp_en);
    check("lcd_rs", lcd_rs, m_rs);
    check("lcd_data", lcd_data, m_data);
    check("lcd_on", lcd_on, m_on);
    check("lcd_rw", lcd_rw, 1'b0);
    if (lcd_en === 1'b1 && !prev_en) obs_pulses++;
    prev_en = (lcd_en === 1'b1);
  endtask

  // Offer one byte and keep req_valid high until the model accepts it.
  task automatic send(input bit rs, input logic [7:0] d, input bit drop_valid);
    int t;
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    t = 0;
    do begin
      step();
      t++;
    end while (!m_acc && t < 300);
    if (!m_acc) check("accept_timeout", 0, 1);
    if (drop_valid) req_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();

    // single data byte, then clear command
    send(1'b1, 8'h41, 1'b1);
    repeat (15) step();
    send(1'b0, 8'h01, 1'b1);
    repeat (30) step();

    // valid held high across two bytes; data changes while busy
    send(1'b1, 8'h48, 1'b0);
    req_data = 8'h49;
    step();
    req_data = 8'h4A;
    step();
    req_data = 8'h49;
    t = 0;
    do begin
      step();
      t++;
    end while (!m_acc && t < 300);
    if (!m_acc) check("b2b_timeout", 0, 1);
    req_valid = 1'b0;
    repeat (15) step();

    // reset while EN is high
    send(1'b1, 8'h55, 1'b1);
    t = 0;
    while (!(edge_n >= en_on && edge_n < en_off) && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) check("pulse_timeout", 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_rs    = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) req_data = 8'($urandom_range(1, 3));
      else req_data = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    repeat (120) step();

    check("en_pulse_count", obs_pulses, m_pulses);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
